scoreboard_controller: RTL

- Front-end controller that produces the single-cycle `inc_i` / `dec_i` / `erase_i` command pulses consumed by the 2-digit BCD scoreboard counter.
- Turns three raw, bouncy, asynchronous push-buttons into clean, mutually exclusive pulses.
- Adds hold-to-auto-repeat for increment and decrement.
- Sits between the board buttons and the counter, in the same clock domain as the counter.

---
 rtl/scoreboard_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/scoreboard_controller.sv
// Purpose : debounces three raw push-buttons and turns them into clean, mutually
//           exclusive one-cycle inc/dec/erase pulses, with hold-to-repeat on inc/dec.
// Latency : button first sampled high at edge 1 -> pulse in the cycle after edge DEB_CYCLES+3.
// Backpressure: none; the downstream counter must accept a pulse every cycle.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   btn_inc_i, btn_dec_i, btn_clr_i  raw asynchronous buttons, active high
//   inc_o, dec_o, erase_o            registered one-cycle command pulses
//   repeat_o                         registered, high while auto-repeating
module scoreboard_controller #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned REP_DELAY  = 16,
    parameter int unsigned REP_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_inc_i,
    input  logic btn_dec_i,
    input  logic btn_clr_i,
    output logic inc_o,
    output logic dec_o,
    output logic erase_o,
    output logic repeat_o
);

    localparam logic [7:0]  DEB_LAST    = 8'(DEB_CYCLES - 1);
    localparam logic [15:0] DELAY_LAST  = 16'(REP_DELAY - 1);
    localparam logic [15:0] PERIOD_LAST = 16'(REP_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        INC_WAIT,
        INC_REP,
        DEC_WAIT,
        DEC_REP,
        LOCK
    } state_t;

    // Bit order in all per-button vectors: [0]=inc, [1]=dec, [2]=clr.
    logic [2:0]      raw_btn;
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0]      deb_lvl_q;
    logic [2:0]      deb_lvl_d;
    logic [2:0][7:0] deb_cnt_q;
    logic [2:0][7:0] deb_cnt_d;

    state_t      state_q;
    logic [15:0] timer_q;
    logic        inc_q;
    logic        dec_q;
    logic        erase_q;
    logic        repeat_q;

    assign raw_btn = {btn_clr_i, btn_dec_i, btn_inc_i};

    // Two-flop synchronizers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= raw_btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the level flips only after DEB_CYCLES consecutive disagreeing
    // samples; any agreeing sample restarts the count.
    always_comb begin
        deb_cnt_d = '0;
        deb_lvl_d = deb_lvl_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != deb_lvl_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_lvl_d[i] = ~deb_lvl_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl_q <= 3'b000;
            deb_cnt_q <= '0;
        end else begin
            deb_lvl_q <= deb_lvl_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Inc and dec hold states share one code path: "own" is the button being
    // held, "other" is the opposing one whose press forces a lockout.
    logic        lvl_inc;
    logic        lvl_dec;
    logic        lvl_clr;
    logic        inc_side;
    logic        in_rep;
    logic        own_lvl;
    logic        oth_lvl;
    logic [15:0] tmr_last;

    assign lvl_inc  = deb_lvl_q[0];
    assign lvl_dec  = deb_lvl_q[1];
    assign lvl_clr  = deb_lvl_q[2];
    assign inc_side = (state_q == INC_WAIT) || (state_q == INC_REP);
    assign in_rep   = (state_q == INC_REP)  || (state_q == DEC_REP);
    assign own_lvl  = inc_side ? lvl_inc : lvl_dec;
    assign oth_lvl  = inc_side ? lvl_dec : lvl_inc;
    assign tmr_last = in_rep ? PERIOD_LAST : DELAY_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= 16'd0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            erase_q  <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            // Pulses are one cycle wide unless a branch below re-asserts them.
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            erase_q  <= 1'b0;
            repeat_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lvl_clr) begin
                        erase_q <= 1'b1;
                        state_q <= LOCK;
                    end else if (lvl_inc && !lvl_dec) begin
                        inc_q   <= 1'b1;
                        timer_q <= 16'd0;
                        state_q <= INC_WAIT;
                    end else if (lvl_dec && !lvl_inc) begin
                        dec_q   <= 1'b1;
                        timer_q <= 16'd0;
                        state_q <= DEC_WAIT;
                    end else if (lvl_inc && lvl_dec) begin
                        state_q <= LOCK;
                    end
                end
                INC_WAIT, INC_REP, DEC_WAIT, DEC_REP: begin
                    if (lvl_clr) begin
                        erase_q <= 1'b1;
                        state_q <= LOCK;
                    end else if (oth_lvl) begin
                        state_q <= LOCK;
                    end else if (!own_lvl) begin
                        state_q <= IDLE;
                    end else if (timer_q == tmr_last) begin
                        inc_q    <= inc_side;
                        dec_q    <= !inc_side;
                        timer_q  <= 16'd0;
                        repeat_q <= 1'b1;
                        state_q  <= inc_side ? INC_REP : DEC_REP;
                    end else begin
                        timer_q  <= timer_q + 16'd1;
                        repeat_q <= in_rep;
                    end
                end
                LOCK: begin
                    // Wait for a full release so a held clr or a double press never re-fires.
                    if (!lvl_inc && !lvl_dec && !lvl_clr) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inc_o    = inc_q;
    assign dec_o    = dec_q;
    assign erase_o  = erase_q;
    assign repeat_o = repeat_q;

endmodule
